// File: rtl/count_sampler.sv
// Periodic sampler of a shared count bus: drives out_e for one cycle every SAMPLE_DIV+1
// cycles, captures bus_in with a wrap flag, and buffers the samples in a small FIFO.
module count_sampler #(
  parameter int SAMPLE_DIV = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] bus_in,
  output logic       out_e,
  input  logic       clr_ovf,
  output logic       s_valid,
  input  logic       s_ready,
  output logic [7:0] s_data,
  output logic       s_wrap,
  output logic       ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] div_reg, div_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      div_reg   <= '0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    case (state_reg)
      IDLE: begin
        div_next = '0;
        if (enable) state_next = WAIT;
      end
      WAIT: begin
        // Dropping enable abandons the pending sample, even on the last divider count.
        if (!enable) begin
          state_next = IDLE;
          div_next   = '0;
        end else if (div_reg == DIV_LAST) begin
          state_next = DRIVE;
          div_next   = '0;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end
      DRIVE: begin
        div_next   = '0;
        state_next = enable ? WAIT : IDLE;
      end
      default: begin
        state_next = IDLE;
        div_next   = '0;
      end
    endcase
  end

  assign out_e = (state_reg == DRIVE);

  // The upstream counter drives the bus throughout DRIVE; sample at the edge that ends it.
  logic       capture;
  logic       wrap;
  logic [7:0] prev_reg;
  logic       prev_valid_reg;

  assign capture = out_e;
  assign wrap    = prev_valid_reg && (bus_in < prev_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
    end else if (capture) begin
      prev_reg       <= bus_in;
      prev_valid_reg <= 1'b1;
    end
  end

  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [8:0]  mem [FIFO_DEPTH];
  logic [8:0]  head;
  logic        empty, full, push, pop, drop;
  logic        ovf_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = s_valid && s_ready;
  assign push  = capture && (!full || pop);
  assign drop  = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {wrap, bus_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (drop)         ovf_reg <= 1'b1;
      else if (clr_ovf) ovf_reg <= 1'b0;
    end
  end

  // Head is masked while empty so stale memory never shows on the outputs.
  assign head    = mem[rd_ptr_reg[AW-1:0]];
  assign s_valid = !empty;
  assign s_data  = s_valid ? head[7:0] : 8'd0;
  assign s_wrap  = s_valid ? head[8] : 1'b0;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_count_sampler.sv
// Directed bench for count_sampler with SAMPLE_DIV=4, FIFO_DEPTH=4: a cycle table for
// sampling and wrap detection, plus sequences for overflow, full push/pop, enable and reset.
module tb_count_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       s_ready = 1'b0;
  logic       use_cnt = 1'b0;
  logic [7:0] bus_tbl = 8'hAA;
  logic [7:0] cnt;
  logic [7:0] bus_in;
  logic       out_e, s_valid, s_wrap, ovf;
  logic [7:0] s_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Free-running upstream counter
  always @(posedge clk) begin
    if (rst) cnt <= 8'd0;
    else     cnt <= cnt + 8'd1;
  end

  assign bus_in = use_cnt ? cnt : bus_tbl;

  count_sampler #(.SAMPLE_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus_in(bus_in), .out_e(out_e),
    .clr_ovf(clr_ovf), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_wrap(s_wrap), .ovf(ovf)
  );

  typedef struct {
    logic       en;
    logic [7:0] bus;
    logic       exp_oe;
    logic       exp_sv;
    logic [7:0] exp_data;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; s_ready = 1'b0; clr_ovf = 1'b0;
    use_cnt = 1'b0; bus_tbl = 8'hAA;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_drive(input string name, output int cycles);
    cycles = 0;
    while (!out_e && cycles < 20) begin
      tick();
      cycles++;
    end
    if (!out_e) check({name, "_drive_timeout"}, 0, 1);
  endtask

  function automatic vec_t mk(logic [7:0] bus, logic oe, logic sv, logic [7:0] d, logic w);
    vec_t v;
    v.en = 1'b1; v.bus = bus; v.exp_oe = oe; v.exp_sv = sv; v.exp_data = d; v.exp_wrap = w;
    return v;
  endfunction

  initial begin
    int c;
    int seen;
    logic [7:0] v [6];
    logic [7:0] prev;
    logic [7:0] dlt;

    // Reset state
    tick();
    check("rst_out_e", int'(out_e), 0);
    check("rst_s_valid", int'(s_valid), 0);
    check("rst_s_data", int'(s_data), 0);
    check("rst_s_wrap", int'(s_wrap), 0);
    check("rst_ovf", int'(ovf), 0);
    do_reset();

    // Cycle table: samples 250, 3 (wrap), 8 (no wrap); junk on bus otherwise
    for (int i = 0; i < 17; i++) vecs[i] = mk(8'hAA, 1'b0, 1'b0, 8'd0, 1'b0);
    vecs[4]  = mk(8'hAA, 1'b1, 1'b0, 8'd0, 1'b0);
    vecs[5]  = mk(8'd250, 1'b0, 1'b1, 8'd250, 1'b0);
    vecs[9]  = mk(8'hAA, 1'b1, 1'b0, 8'd0, 1'b0);
    vecs[10] = mk(8'd3, 1'b0, 1'b1, 8'd3, 1'b1);
    vecs[14] = mk(8'hAA, 1'b1, 1'b0, 8'd0, 1'b0);
    vecs[15] = mk(8'd8, 1'b0, 1'b1, 8'd8, 1'b0);
    s_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      enable = vecs[i].en;
      bus_tbl = vecs[i].bus;
      tick();
      check($sformatf("vec%0d_out_e", i), int'(out_e), int'(vecs[i].exp_oe));
      check($sformatf("vec%0d_s_valid", i), int'(s_valid), int'(vecs[i].exp_sv));
      check($sformatf("vec%0d_ovf", i), int'(ovf), 0);
      if (vecs[i].exp_sv) begin
        check($sformatf("vec%0d_s_data", i), int'(s_data), int'(vecs[i].exp_data));
        check($sformatf("vec%0d_s_wrap", i), int'(s_wrap), int'(vecs[i].exp_wrap));
      end
    end

    // Periodic sampling from a free-running counter
    do_reset();
    use_cnt = 1'b1; enable = 1'b1; s_ready = 1'b1;
    prev = 8'd0;
    for (int i = 0; i < 4; i++) begin
      wait_drive("periodic", c);
      check($sformatf("periodic%0d_gap", i), c, (i == 0) ? 5 : 4);
      v[0] = bus_in;
      tick();
      check($sformatf("periodic%0d_pulse_len", i), int'(out_e), 0);
      check($sformatf("periodic%0d_s_valid", i), int'(s_valid), 1);
      check($sformatf("periodic%0d_s_data", i), int'(s_data), int'(v[0]));
      check($sformatf("periodic%0d_s_wrap", i), int'(s_wrap), 0);
      if (i > 0) begin
        dlt = v[0] - prev;
        check($sformatf("periodic%0d_delta", i), int'(dlt), 5);
      end
      prev = v[0];
    end

    // Overflow: five samples with no consumer, then clr_ovf against a drop and alone
    do_reset();
    use_cnt = 1'b1; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_drive("ovf", c);
      v[i] = bus_in;
      tick();
      if (i == 3) begin
        check("ovf_full_s_valid", int'(s_valid), 1);
        check("ovf_full_no_ovf", int'(ovf), 0);
      end
    end
    check("ovf_dropped_set", int'(ovf), 1);
    check("ovf_head_kept", int'(s_data), int'(v[0]));
    wait_drive("ovf_clr", c);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_set_wins", int'(ovf), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", int'(ovf), 0);
    enable = 1'b0;
    tick();
    s_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d_valid", i), int'(s_valid), 1);
      check($sformatf("ovf_drain%0d_data", i), int'(s_data), int'(v[i]));
      tick();
    end
    check("ovf_drain_empty", int'(s_valid), 0);

    // Full FIFO with a pop in the capture cycle
    do_reset();
    use_cnt = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_drive("fullpp", c);
      v[i] = bus_in;
      tick();
    end
    wait_drive("fullpp_last", c);
    v[4] = bus_in;
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    check("fullpp_ovf", int'(ovf), 0);
    check("fullpp_head", int'(s_data), int'(v[1]));
    enable = 1'b0;
    tick();
    s_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("fullpp_drain%0d_valid", i), int'(s_valid), 1);
      check($sformatf("fullpp_drain%0d_data", i), int'(s_data), int'(v[i]));
      tick();
    end
    check("fullpp_empty", int'(s_valid), 0);

    // Enable drop mid-WAIT, then during DRIVE
    do_reset();
    use_cnt = 1'b1; enable = 1'b1;
    tick(); tick(); tick();
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_e) seen = 1;
    end
    check("endrop_wait_no_pulse", seen, 0);
    check("endrop_wait_no_entry", int'(s_valid), 0);
    enable = 1'b1;
    wait_drive("endrop", c);
    check("endrop_restart_gap", c, 5);
    v[0] = bus_in;
    enable = 1'b0;
    tick();
    check("endrop_drive_done", int'(out_e), 0);
    check("endrop_drive_valid", int'(s_valid), 1);
    check("endrop_drive_data", int'(s_data), int'(v[0]));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_e) seen = 1;
    end
    check("endrop_idle_no_pulse", seen, 0);

    // Reset while out_e is high
    do_reset();
    use_cnt = 1'b1; enable = 1'b1;
    wait_drive("rstdrive", c);
    #2 rst = 1'b1;
    #1;
    check("rstdrive_out_e", int'(out_e), 0);
    check("rstdrive_s_valid", int'(s_valid), 0);
    check("rstdrive_ovf", int'(ovf), 0);
    tick();
    rst = 1'b0;
    enable = 1'b0;
    tick(); tick(); tick();
    check("rstdrive_no_entry", int'(s_valid), 0);
    check("rstdrive_no_ovf", int'(ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
